// File: rtl/data_memory_arbiter.sv
// Shares the data-memory port between the execute stage and a DMA/debug requester.
// Optional wait-cycle statistics are enabled by defining DATA_MEMORY_ARBITER_STATS_EN.
module data_memory_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_data_out,
  output logic [DATA_W-1:0] cpu_data_in,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_address,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in
`ifdef DATA_MEMORY_ARBITER_STATS_EN
  ,
  output logic [15:0]       cpu_wait_cycles,
  output logic [15:0]       dma_wait_cycles
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [2:0] LAST_WAIT  = 3'(MEM_LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [0:0]        state_r;
  logic              owner_dma_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [2:0]        wait_r;
  logic [3:0]        starve_r;

  logic cpu_req_s;
  logic dma_win_s;
  logic grant_s;
  logic busy_s;
  logic done_s;
  logic cpu_done_s;

  // Arbitration and completion decode
  always_comb begin
    cpu_req_s  = cpu_read | cpu_write;
    busy_s     = (state_r == BUSY);
    dma_win_s  = dma_req & ((starve_r == STARVE_MAX) | ~cpu_req_s);
    grant_s    = ~busy_s & (cpu_req_s | dma_req);
    done_s     = busy_s & (we_r | (wait_r == LAST_WAIT));
    cpu_done_s = done_s & ~owner_dma_r;
  end

  // FSM and access latches; a write occupies exactly one BUSY cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      owner_dma_r <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      wait_r      <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            state_r     <= BUSY;
            owner_dma_r <= dma_win_s;
            we_r        <= dma_win_s ? dma_we : cpu_write;
            addr_r      <= dma_win_s ? dma_address : cpu_address;
            wdata_r     <= dma_win_s ? dma_wdata : cpu_data_out;
            wait_r      <= 3'd0;
          end
        end
        BUSY: begin
          if (done_s) begin
            state_r <= IDLE;
          end else begin
            wait_r <= wait_r + 3'd1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // DMA starvation guard: counts cycles a pending DMA request loses to the CPU
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_r <= 4'd0;
    end else if (grant_s & dma_win_s) begin
      starve_r <= 4'd0;
    end else if (dma_req & (grant_s | (busy_s & ~owner_dma_r)) & (starve_r != STARVE_MAX)) begin
      starve_r <= starve_r + 4'd1;
    end
  end

  // Memory strobes and returned data; everything reads 0 outside BUSY
  always_comb begin
    mem_read     = busy_s & ~we_r;
    mem_write    = busy_s & we_r;
    mem_address  = busy_s ? addr_r : '0;
    mem_data_out = busy_s ? wdata_r : '0;
    cpu_stall    = cpu_req_s & ~cpu_done_s;
    dma_ack      = done_s & owner_dma_r;
    if (cpu_done_s & ~we_r) begin
      cpu_data_in = mem_data_in;
    end else begin
      cpu_data_in = '0;
    end
    if (dma_ack & ~we_r) begin
      dma_rdata = mem_data_in;
    end else begin
      dma_rdata = '0;
    end
  end

`ifdef DATA_MEMORY_ARBITER_STATS_EN
  // Saturating wait-cycle statistics
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cpu_wait_cycles <= 16'd0;
      dma_wait_cycles <= 16'd0;
    end else begin
      if (cpu_stall && (cpu_wait_cycles != 16'hFFFF)) begin
        cpu_wait_cycles <= cpu_wait_cycles + 16'd1;
      end
      if (dma_req && !dma_ack && (dma_wait_cycles != 16'hFFFF)) begin
        dma_wait_cycles <= dma_wait_cycles + 16'd1;
      end
    end
  end
`endif

endmodule
